// File: rtl/showcase_pipe_if.sv
// showcase_pipe_if: valid/ready operand and result bundle for showcase_pipe
interface showcase_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  in_vld;
  logic                  in_rd;
  logic [DATA_WIDTH-1:0] out_c;
  logic [5:0]            out_cmp;
  logic [OUT_WIDTH-1:0]  out_sc;
  logic                  out_vld;
  logic                  out_rd;
  modport master (output a, b, in_vld, out_rd, input in_rd, out_c, out_cmp, out_sc, out_vld);
  modport slave  (input a, b, in_vld, out_rd, output in_rd, out_c, out_cmp, out_sc, out_vld);
endinterface

// File: rtl/showcase_pipe.sv
// showcase_pipe: two-stage handshaked arithmetic pipe, delayed ROM read, sticky flag and saturating counter
module showcase_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int CMP_CONST  = 4,
  parameter int DELAY      = 2,
  parameter int ROM_DEPTH  = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int ADDR_W    = $clog2(ROM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  showcase_pipe_if.slave       bus,
  input  logic [ADDR_W-1:0]    addr,
  output logic [OUT_WIDTH-1:0] rom_q,
  input  logic                 e,
  input  logic                 clr,
  output logic                 flag,
  output logic [CNT_WIDTH-1:0] cnt
);
  localparam logic        [DATA_WIDTH-1:0] KU = DATA_WIDTH'(CMP_CONST);
  localparam logic signed [DATA_WIDTH-1:0] KS = DATA_WIDTH'(CMP_CONST);
  logic                  s2_load, s1_load, in_fire, out_load;
  logic                  s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] s1_c_q, s1_c_d, out_c_q, out_c_d;
  logic [5:0]            s1_cmp_q, s1_cmp_d, out_cmp_q, out_cmp_d;
  logic [OUT_WIDTH-1:0]  s1_sc_q, s1_sc_d, out_sc_q, out_sc_d;
  logic [ADDR_W-1:0]     dl_q [DELAY];
  logic [ADDR_W-1:0]     dl_d [DELAY];
  logic [OUT_WIDTH-1:0]  rom [ROM_DEPTH];
  logic [OUT_WIDTH-1:0]  rom_q_q, rom_q_d;
  logic                  flag_q, flag_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  always_comb
    for (int k = 0; k < ROM_DEPTH; k++) rom[k] = OUT_WIDTH'(k);
  always_comb begin
    s2_load   = !out_vld_q | bus.out_rd;
    s1_load   = !s1_vld_q | s2_load;
    in_fire   = bus.in_vld & s1_load & !rst;
    s1_vld_d  = s1_load ? in_fire : s1_vld_q;
    s1_c_d    = in_fire ? bus.a + bus.b : s1_c_q;
    s1_cmp_d  = in_fire ? {$signed(bus.b) == KS, $signed(bus.b) != KS, $signed(bus.b) >= KS,
                           $signed(bus.b) <= KS, bus.a > KU, bus.a < KU} : s1_cmp_q;
    s1_sc_d   = in_fire ? OUT_WIDTH'(bus.a == 1 ? 3'd0 : bus.a == 2 ? 3'd1 : bus.a == 3 ? 3'd3 : 3'd4)
                        : s1_sc_q;
    out_load  = s2_load & s1_vld_q;
    out_vld_d = s2_load ? s1_vld_q : out_vld_q;
    out_c_d   = out_load ? s1_c_q : out_c_q;
    out_cmp_d = out_load ? s1_cmp_q : out_cmp_q;
    out_sc_d  = out_load ? s1_sc_q : out_sc_q;
    dl_d[0]   = addr;
    for (int i = 1; i < DELAY; i++) dl_d[i] = dl_q[i-1];
    rom_q_d   = rom[dl_q[DELAY-1]];
    flag_d    = clr ? 1'b0 : flag_q | e;
    cnt_d     = clr ? '0 : (in_fire && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_c_q    <= '0;
      s1_cmp_q  <= '0;
      s1_sc_q   <= '0;
      out_vld_q <= 1'b0;
      out_c_q   <= '0;
      out_cmp_q <= '0;
      out_sc_q  <= '0;
      dl_q      <= '{default: '0};
      rom_q_q   <= '0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_c_q    <= s1_c_d;
      s1_cmp_q  <= s1_cmp_d;
      s1_sc_q   <= s1_sc_d;
      out_vld_q <= out_vld_d;
      out_c_q   <= out_c_d;
      out_cmp_q <= out_cmp_d;
      out_sc_q  <= out_sc_d;
      dl_q      <= dl_d;
      rom_q_q   <= rom_q_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
    end
  assign bus.in_rd   = s1_load & !rst;
  assign bus.out_vld = out_vld_q;
  assign bus.out_c   = out_c_q;
  assign bus.out_cmp = out_cmp_q;
  assign bus.out_sc  = out_sc_q;
  assign rom_q       = rom_q_q;
  assign flag        = flag_q;
  assign cnt         = cnt_q;
endmodule

// File: tb/tb_showcase_pipe.sv
// tb_showcase_pipe: directed self-checking bench for showcase_pipe
module tb_showcase_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] addr;
  logic [7:0] rom_q;
  logic       e, clr, flag;
  logic [7:0] cnt;
  int         n_cmp = 0;
  int         n_err = 0;
  showcase_pipe_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) bus ();
  showcase_pipe #(.DATA_WIDTH(32), .OUT_WIDTH(8), .CMP_CONST(4), .DELAY(2), .ROM_DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .addr(addr), .rom_q(rom_q),
    .e(e), .clr(clr), .flag(flag), .cnt(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int c, nxt, got;
    logic fire;
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    rst = 1'b1; addr = 2'd0; e = 1'b0; clr = 1'b0;
    bus.a = 32'd1; bus.b = 32'd0; bus.in_vld = 1'b1; bus.out_rd = 1'b1;
    repeat (3) tick();
    chk("rst_in_rd", bus.in_rd, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_c", bus.out_c, 0);
    chk("rst_out_cmp", bus.out_cmp, 0);
    chk("rst_out_sc", bus.out_sc, 0);
    chk("rst_rom_q", rom_q, 0);
    chk("rst_flag", flag, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b0; bus.in_vld = 1'b0;
    tick();
    chk("rel_in_rd", bus.in_rd, 1);
    chk("rel_out_vld", bus.out_vld, 0);
    bus.a = 32'd3; bus.b = 32'hFFFF_FFF9; bus.in_vld = 1'b1;
    tick();
    bus.a = 32'd4; bus.b = 32'd4;
    tick();
    chk("ar1_vld", bus.out_vld, 1);
    chk("ar1_c", bus.out_c, 32'hFFFF_FFFC);
    chk("ar1_cmp", bus.out_cmp, 6'b010101);
    chk("ar1_sc", bus.out_sc, 3);
    bus.in_vld = 1'b0;
    tick();
    chk("ar2_vld", bus.out_vld, 1);
    chk("ar2_c", bus.out_c, 8);
    chk("ar2_cmp", bus.out_cmp, 6'b101100);
    chk("ar2_sc", bus.out_sc, 4);
    tick();
    chk("ar_drain", bus.out_vld, 0);
    chk("ar_cnt", cnt, 2);
    e = 1'b1;
    tick();
    e = 1'b0;
    tick();
    chk("flag_set", flag, 1);
    tick();
    chk("flag_hold", flag, 1);
    clr = 1'b1; e = 1'b1;
    tick();
    clr = 1'b0; e = 1'b0;
    chk("clr_flag", flag, 0);
    chk("clr_cnt", cnt, 0);
    c = 0; nxt = 1; got = 0;
    bus.a = 32'd1; bus.b = 32'd0; bus.in_vld = 1'b1;
    while (got < 5 && c < 40) begin
      bus.out_rd = (c >= 4);
      @(negedge clk);
      if (c == 3) begin
        chk("bp_stall_rd", bus.in_rd, 0);
        chk("bp_accepts", nxt - 1, 2);
      end
      if (bus.out_vld && bus.out_rd) begin
        got++;
        chk("bp_data", bus.out_c, got);
      end
      fire = bus.in_vld & bus.in_rd;
      tick();
      if (fire) begin
        nxt++;
        if (nxt > 5) bus.in_vld = 1'b0;
        else bus.a = nxt;
      end
      c++;
    end
    chk("bp_count", got, 5);
    chk("bp_empty", bus.out_vld, 0);
    chk("bp_cnt", cnt, 5);
    addr = 2'd2;
    repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      addr = (i < 5) ? seq[i] : 2'd2;
      tick();
      if (i >= 2) chk("rom_q", rom_q, seq[i-2]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_vld = 1'b1; bus.out_rd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.a = i;
      tick();
      if (i == 253) chk("cnt_254", cnt, 254);
    end
    chk("cnt_sat", cnt, 255);
    bus.in_vld = 1'b0;
    repeat (2) tick();
    bus.out_rd = 1'b0; bus.in_vld = 1'b1; bus.a = 32'd9;
    repeat (2) tick();
    bus.in_vld = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; bus.out_rd = 1'b1;
    chk("mr_cnt", cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_vld", bus.out_vld, 0);
    end
    bus.a = 32'd6; bus.b = 32'd1; bus.in_vld = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    tick();
    chk("mr_new_vld", bus.out_vld, 1);
    chk("mr_new_c", bus.out_c, 7);
    chk("mr_new_cnt", cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
